// File: rtl/mem_if_pkg.sv
// mem_if_pkg: definitions shared by the data-side memory responder and the
// future instruction-fetch responder.
//   state_e       responder FSM states
//   SZ_*          access size encodings (2'b11 behaves as a word)
//   lane_align    forces the low address bits of a misaligned access to 0
//   lane_misalign flags halfword/word accesses that are not naturally aligned
//   lane_be       per-byte write enables for an access
//   lane_merge    replicates store data so every addressed lane carries it
//   lane_extract  shifts addressed lanes down and zero-extends
package mem_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP,
    ST_HOLD
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic [1:0] lane_align(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic lane_misalign(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replication places the data in whichever lanes lane_be enables, so no
  // offset-dependent shift is needed on the write path.
  function automatic logic [31:0] lane_merge(input logic [31:0] wdata, input logic [1:0] size);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: return {24'b0, shifted[7:0]};
      SZ_HALF: return {16'b0, shifted[15:0]};
      default: return shifted;
    endcase
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// mem_word_ram: synchronous single-port MEM_WORDS x 32 RAM.
//   clk      clock
//   rst_n    synchronous active-low reset; blocks the write on a reset edge
//   we_i     write strobe
//   be_i     per-byte write enables
//   idx_i    word index
//   wdata_i  write data (lane-aligned)
//   rdata_o  registered read data of idx_i (old contents on a write)
// Contents are not reset.
module mem_word_ram #(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    rdata_q <= mem_q[idx_i];
    for (int i = 0; i < 4; i++) begin
      if (we_i && rst_n && be_i[i]) begin
        mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the core's load/store path.
// Captures one request, counts WAIT_CYCLES wait states, performs a single
// RAM access and returns a one-cycle ack with zero-extended load data.
//   clk, rst_n   clock, synchronous active-low reset
//   req          request strobe, held by the requester until ack
//   we, size     direction (1 = store) and size (byte/half/word)
//   addr, wdata  byte address, right-justified store data
//   rdata        load data, valid with ack (0 for stores)
//   ack          one-cycle completion pulse
//   busy         high whenever the FSM is not idle
//   fault        misalignment flag qualified by ack
// Build option DATA_MEM_RESPONDER_ALIGN_CHECK_EN: misaligned requests are
// answered immediately with fault=1 and no RAM access. Without it, fault is
// tied 0 and misaligned low address bits are forced to 0.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        fault
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ram_we;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_rdata;
  logic          unused_addr_hi;

  // Upper address bits only select aliases of the same word.
  assign unused_addr_hi = ^addr[31:AW+2];

`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic misaligned;
  assign misaligned = lane_misalign(size, addr[1:0]);
`endif

  // The RAM read is registered, so the index follows the live address while
  // idle; read data is then ready in ACCESS even with zero wait states.
  assign ram_idx = (state_q == ST_IDLE) ? addr[AW+1:2] : addr_q[AW+1:2];

  mem_word_ram #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (ram_we),
    .be_i   (lane_be(size_q, addr_q[1:0])),
    .idx_i  (ram_idx),
    .wdata_i(lane_merge(wdata_q, size_q)),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ram_we  = 1'b0;
`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          addr_d  = {addr[AW+1:2], lane_align(size, addr[1:0])};
          wdata_d = wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
          fault_d = misaligned;
          if (misaligned) begin
            cnt_d   = '0;
            rdata_d = '0;
            state_d = ST_RESP;
          end
`endif
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        ram_we  = we_q;
        rdata_d = we_q ? 32'd0 : lane_extract(ram_rdata, size_q, addr_q[1:0]);
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_HOLD;
      ST_HOLD: if (!req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign ack   = (state_q == ST_RESP);
  assign busy  = (state_q != ST_IDLE);
  assign rdata = rdata_q;
`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
  assign fault = ack & fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a byte-addressed reference memory predicts
// each response; a monitor checks every ack against the scoreboard queue.
module tb_data_mem_responder;

  localparam int MW = 256;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        rst_n, req, we;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        ack, busy, fault;
  logic        req0, we0;
  logic [1:0]  size0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ack0, busy0, fault0;

  always #5 clk = ~clk;

  data_mem_responder #(.MEM_WORDS(MW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy), .fault(fault)
  );

  data_mem_responder #(.MEM_WORDS(MW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .size(size0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ack(ack0), .busy(busy0), .fault(fault0)
  );

  typedef struct {
    logic [31:0] rd;
    logic        ft;
    int          cy;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] mem_m [4*MW];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic       ack_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the oldest expected response.
  always @(negedge clk) begin
    if (ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {31'b0, ack}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rdata", rdata, mon_e.rd);
        chk("fault", {31'b0, fault}, {31'b0, mon_e.ft});
        chk("ack_latency", cyc, mon_e.cy);
      end
      if (ack_prev) chk("ack_single_cycle", {31'b0, ack_prev}, 32'd0);
    end
    ack_prev <= ack;
  end

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic do_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
    exp_t e;
    int   n, base, t;
    bit   upd;
    n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    e.rd = 32'd0;
    e.ft = 1'b0;
    e.cy = cyc + WC + 2;
    upd  = 1'b1;
`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
    if ((a % n) != 0) begin
      e.ft = 1'b1;
      e.cy = cyc + 1;
      upd  = 1'b0;
    end
`endif
    if (upd) begin
      base = int'(a % (4 * MW)) / n * n;
      for (int i = 0; i < n; i++) begin
        if (w) mem_m[base + i] = wd[8*i +: 8];
        else   e.rd[8*i +: 8]  = mem_m[base + i];
      end
    end
    sb.push_back(e);
    chk("busy_idle", {31'b0, busy}, 32'd0);
    req = 1'b1; we = w; size = sz; addr = a; wdata = wd;
    @(posedge clk); #1;
    chk("busy_after_capture", {31'b0, busy}, 32'd1);
    // Inputs are scrambled after capture; the DUT must ignore them.
    we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
    t = 0;
    while (ack !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("ack_timeout", {31'b0, ack}, 32'd1);
    req = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 10);
    chk("busy_release", {31'b0, busy}, 32'd0);
  endtask

  // Store aborted by reset k edges after capture (k=2 hits the ACCESS edge).
  task automatic reset_during(input logic [31:0] a, input logic [31:0] wd, input int k);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = a; wdata = wd;
    @(posedge clk); #1;
    repeat (k) @(posedge clk);
    #1;
    chk("busy_before_reset", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_reset", {31'b0, busy}, 32'd0);
    chk("ack_after_reset", {31'b0, ack}, 32'd0);
    chk("rdata_after_reset", rdata, 32'd0);
    req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int acks, ack_cyc, c, t;
    logic [31:0] v;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; size0 = 2'b00; addr0 = '0; wdata0 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy0", {31'b0, busy0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < MW; i++) do_txn(1'b1, 2'b10, 32'(4 * i), $urandom);

    do_txn(1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
    do_txn(1'b0, 2'b00, 32'h12, 32'h0);
    do_txn(1'b0, 2'b01, 32'h12, 32'h0);
    do_txn(1'b1, 2'b00, 32'h11, 32'h55);
    do_txn(1'b0, 2'b10, 32'h10, 32'h0);
    do_txn(1'b1, 2'b10, 32'h400, 32'hCAFEF00D);
    do_txn(1'b0, 2'b10, 32'h000, 32'h0);
    do_txn(1'b0, 2'b10, 32'h13, 32'h0);
    do_txn(1'b1, 2'b11, 32'h0000_0AA7, 32'h1234_5678);
    do_txn(1'b0, 2'b11, 32'h0000_0AA4, 32'h0);

    reset_during(32'h40, 32'h1111_2222, 0);
    do_txn(1'b0, 2'b10, 32'h40, 32'h0);
    reset_during(32'h44, 32'h3333_4444, 2);
    do_txn(1'b0, 2'b10, 32'h44, 32'h0);

    for (int i = 0; i < 300; i++)
      do_txn(1'($urandom), 2'($urandom), $urandom, $urandom);

    // Zero wait states with req held for five edges: one ack only.
    v = $urandom;
    c = cyc; acks = 0; ack_cyc = -1;
    req0 = 1'b1; we0 = 1'b1; size0 = 2'b10; addr0 = 32'h20; wdata0 = v;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack0) begin
        acks++;
        ack_cyc = cyc;
        chk("w0_store_rdata", rdata0, 32'd0);
      end
      chk("w0_busy_held", {31'b0, busy0}, 32'd1);
    end
    @(negedge clk);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("w0_busy_drop", {31'b0, busy0}, 32'd0);
    chk("w0_ack_count", acks, 32'd1);
    chk("w0_ack_latency", ack_cyc, c + 2);
    @(negedge clk);
    c = cyc;
    req0 = 1'b1; we0 = 1'b0; size0 = 2'b10; addr0 = 32'h20;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ack0 && t < 10);
    chk("w0_load_ack", {31'b0, ack0}, 32'd1);
    chk("w0_load_latency", cyc, c + 2);
    chk("w0_load_rdata", rdata0, v);
    req0 = 1'b0;
    repeat (3) @(negedge clk);

    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
